// File: rtl/tx_module.sv
// UART transmitter.
// Sends one byte per accepted request as a frame: start bit (low), eight data
// bits LSB first, an optional parity bit, and one or two stop bits (high).
// Every bit is held for exactly BPS clocks. A one-clock DONE cycle follows
// the last stop bit. tx_en_sig low freezes the whole block in place, so the
// frame resumes exactly where it stopped.
module tx_module #(
  parameter logic [12:0] BPS       = 13'd434, // clocks per bit, 2..8191
  parameter logic [1:0]  PARITY    = 2'd0,    // 0 none, 1 odd, 2 even
  parameter logic [1:0]  STOP_BITS = 2'd1     // 1 or 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en_sig,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_pin,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] c1_q, c1_d;       // clocks elapsed inside the current bit
  logic [2:0]  bit_q, bit_d;     // index of the data bit on the line
  logic        stop_q, stop_d;   // which stop bit is on the line
  logic [7:0]  shift_q, shift_d; // latched byte, shifted right per data bit
  logic        par_q, par_d;     // XOR of data bits already sent
  logic        pin_d, busy_d, done_d;

  logic        bit_end;
  logic        last_stop;
  logic        parity_en;

  // The current bit period ends on the clock where c1 reaches BPS-1.
  assign bit_end   = (c1_q == (BPS - 13'd1));
  // With a single stop bit, the first stop bit is also the last one.
  assign last_stop = (STOP_BITS == 2'd1) | stop_q;
  assign parity_en = (PARITY != 2'd0);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch. The defaults are "hold", which
    // is exactly what tx_en_sig low must do.
    state_d = state_q;
    c1_d    = c1_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    pin_d   = tx_pin;
    busy_d  = tx_busy;
    done_d  = tx_done;

    if (tx_en_sig) begin
      unique case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            state_d = S_START;
            c1_d    = 13'd0;
            bit_d   = 3'd0;
            stop_d  = 1'b0;
            shift_d = tx_data;
            par_d   = 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            state_d = S_DATA;
            c1_d    = 13'd0;
          end else begin
            c1_d = c1_q + 13'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            c1_d    = 13'd0;
            par_d   = par_q ^ shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = parity_en ? S_PARITY : S_STOP;
            end
          end else begin
            c1_d = c1_q + 13'd1;
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            state_d = S_STOP;
            c1_d    = 13'd0;
          end else begin
            c1_d = c1_q + 13'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            c1_d = 13'd0;
            if (last_stop) begin
              state_d = S_DONE;
            end else begin
              stop_d = 1'b1;
            end
          end else begin
            c1_d = c1_q + 13'd1;
          end
        end

        S_DONE: begin
          // Requests seen here are dropped; the next one is taken in IDLE.
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Outputs are registered, so they are decoded from the state being
      // entered: the line level changes on the same edge as the state.
      unique case (state_d)
        S_IDLE:   pin_d = 1'b1;
        S_START:  pin_d = 1'b0;
        S_DATA:   pin_d = shift_d[0];
        S_PARITY: pin_d = (PARITY == 2'd2) ? par_d : ~par_d;
        default:  pin_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit timing, data path and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q    <= 13'd0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      // NOTE: the shift register is reset as well, so a frame aborted by
      // reset leaves no stale data behind.
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_pin  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      c1_q    <= c1_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_pin  <= pin_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_tx_module.sv
// Testbench for tx_module.
// Four transmitters with BPS=16 run side by side: no parity / 1 stop, even
// parity, odd parity, and no parity / 2 stop. A frame-level model predicts
// {tx_pin, tx_busy, tx_done} of every instance on every clock; directed
// scenarios add hand-computed literal expectations on top.
module tb_tx_module;

  localparam int NI     = 4;
  localparam int BPS_TB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    [NI];
  logic       start [NI];
  logic [7:0] data  [NI];
  logic       pin   [NI];
  logic       busy  [NI];
  logic       done  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tx_module #(.BPS(13'd16), .PARITY(2'd0), .STOP_BITS(2'd1)) u_p0s1 (
    .clk(clk), .rst_n(rst_n), .tx_en_sig(en[0]), .tx_start(start[0]),
    .tx_data(data[0]), .tx_pin(pin[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  tx_module #(.BPS(13'd16), .PARITY(2'd2), .STOP_BITS(2'd1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_en_sig(en[1]), .tx_start(start[1]),
    .tx_data(data[1]), .tx_pin(pin[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  tx_module #(.BPS(13'd16), .PARITY(2'd1), .STOP_BITS(2'd1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_en_sig(en[2]), .tx_start(start[2]),
    .tx_data(data[2]), .tx_pin(pin[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  tx_module #(.BPS(13'd16), .PARITY(2'd0), .STOP_BITS(2'd2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .tx_en_sig(en[3]), .tx_start(start[3]),
    .tx_data(data[3]), .tx_pin(pin[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int par_of(input int i);
    case (i)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // Clocks from the first start-bit clock to the end of the last stop bit.
  function automatic int frame_len(input int i);
    return (9 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i)) * BPS_TB;
  endfunction

  // Expected {pin, busy, done} at frame position tt (0 = idle, 1 = first
  // start-bit clock, frame_len+1 = the DONE clock).
  function automatic logic [2:0] exp_out(input int i, input int tt,
                                         input logic [7:0] b);
    int   idx;
    logic p;
    if (tt == 0) return 3'b100;
    if (tt == frame_len(i) + 1) return 3'b111;
    idx = (tt - 1) / BPS_TB;
    if (idx == 0)                        p = 1'b0;
    else if (idx <= 8)                   p = b[idx-1];
    else if (idx == 9 && par_of(i) == 2) p = ^b;
    else if (idx == 9 && par_of(i) == 1) p = ~(^b);
    else                                 p = 1'b1;
    return {p, 1'b1, 1'b0};
  endfunction

  int         t_m [NI];
  logic [7:0] b_m [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      t_m[i]   = 0;
      b_m[i]   = 8'h00;
      en[i]    = 1'b1;
      start[i] = 1'b0;
      data[i]  = 8'h00;
    end
  end

  // Advance each model by one enabled clock.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        t_m[i] <= 0;
      end else if (en[i]) begin
        if (t_m[i] == 0) begin
          if (start[i]) begin
            t_m[i] <= 1;
            b_m[i] <= data[i];
          end
        end else if (t_m[i] == frame_len(i) + 1) begin
          t_m[i] <= 0;
        end else begin
          t_m[i] <= t_m[i] + 1;
        end
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("model_u%0d", i), {29'd0, pin[i], busy[i], done[i]},
            {29'd0, exp_out(i, t_m[i], b_m[i])});
    end
  end

  // ---------------- directed scenarios ----------------
  // Inputs change 2 time units after the falling edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  int         first_done, done_cnt, cnt, second_start;
  logic [9:0] exp_seq;

  initial begin
    tick();
    tick();
    check("reset_state", {29'd0, pin[0], busy[0], done[0]}, 32'h4);
    rst_n = 1'b1;
    tick();
    tick();

    // 1) 8'h55, no parity, 1 stop: line 0,1,0,1,0,1,0,1,0,1; DONE at 161.
    data[0] = 8'h55; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    exp_seq = 10'b1010101010;
    first_done = 0;
    for (int k = 1; k <= 190; k++) begin
      if (k % 16 == 8 && k / 16 < 10) check("t1_bit", pin[0], exp_seq[k/16]);
      if (k == 1) check("t1_busy_first", busy[0], 1);
      if (k == 162) check("t1_idle_after", {busy[0], done[0]}, 0);
      if (done[0] && first_done == 0) first_done = k;
      tick();
    end
    check("t1_done_cycle", first_done, 161);

    // 2) parity bit for 8'h07 and 8'h03, even and odd.
    data[1] = 8'h07; data[2] = 8'h07; start[1] = 1'b1; start[2] = 1'b1;
    tick();
    start[1] = 1'b0; start[2] = 1'b0;
    for (int k = 1; k <= 185; k++) begin
      if (k == 152) begin
        check("t2_even_07", pin[1], 1);
        check("t2_odd_07", pin[2], 0);
      end
      tick();
    end
    data[1] = 8'h03; data[2] = 8'h03; start[1] = 1'b1; start[2] = 1'b1;
    tick();
    start[1] = 1'b0; start[2] = 1'b0;
    for (int k = 1; k <= 185; k++) begin
      if (k == 152) begin
        check("t2_even_03", pin[1], 0);
        check("t2_odd_03", pin[2], 1);
      end
      tick();
    end

    // 3) 2 stop bits, tx_start held: 8'hA5 then 8'h3C back to back.
    data[3] = 8'hA5; start[3] = 1'b1;
    tick();
    data[3] = 8'h3C;
    done_cnt = 0; cnt = 0; second_start = 0;
    for (int k = 1; k <= 370; k++) begin
      if (done[3]) done_cnt++;
      if (k >= 145 && k <= 178 && pin[3]) cnt++;
      if (k > 178 && !pin[3] && second_start == 0) second_start = k;
      if (k == 180) start[3] = 1'b0;
      tick();
    end
    check("t3_done_pulses", done_cnt, 2);
    check("t3_high_gap", cnt, 34);
    check("t3_second_start", second_start, 179);

    // 4) request for 8'hFF during an 8'h00 frame is ignored.
    data[0] = 8'h00; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    done_cnt = 0; cnt = 0;
    for (int k = 1; k <= 180; k++) begin
      if (done[0]) done_cnt++;
      if (k <= 144 && !pin[0]) cnt++;
      if (k == 50) begin data[0] = 8'hFF; start[0] = 1'b1; end
      if (k == 51) start[0] = 1'b0;
      tick();
    end
    check("t4_done_pulses", done_cnt, 1);
    check("t4_low_cycles", cnt, 144);

    // 5) tx_en_sig low for 50 clocks inside data bit 3 of 8'hC3.
    data[0] = 8'hC3; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    first_done = 0; cnt = 0;
    for (int k = 1; k <= 230; k++) begin
      if (!pin[0]) cnt++;
      if (k == 100) check("t5_frozen_busy", {busy[0], done[0]}, 2);
      if (done[0] && first_done == 0) first_done = k;
      if (k == 70) en[0] = 1'b0;
      if (k == 120) en[0] = 1'b1;
      tick();
    end
    check("t5_low_cycles", cnt, 130);
    check("t5_done_cycle", first_done, 211);

    // 5b) freeze in DONE: tx_done stays high until the DONE cycle completes.
    data[0] = 8'h00; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 175; k++) begin
      if (done[0]) cnt++;
      if (k == 161) en[0] = 1'b0;
      if (k == 166) en[0] = 1'b1;
      if (k == 167) check("t5b_done_cleared", {busy[0], done[0]}, 0);
      tick();
    end
    check("t5b_done_cycles", cnt, 6);

    // 6) reset during data bit 5, then a clean 8'h81 frame.
    data[0] = 8'h00; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 1; k < 100; k++) tick();
    check("t6_before_reset", pin[0], 0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_pin", pin[0], 1);
    check("t6_reset_busy", busy[0], 0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    data[0] = 8'h81; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    first_done = 0;
    for (int k = 1; k <= 175; k++) begin
      if (k == 24) check("t6_bit0", pin[0], 1);
      if (k == 40) check("t6_bit1", pin[0], 0);
      if (k == 136) check("t6_bit7", pin[0], 1);
      if (done[0] && first_done == 0) first_done = k;
      tick();
    end
    check("t6_done_cycle", first_done, 161);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
